// File: rtl/layer_buf_pkg.sv
// Shared types and default geometry for the layer result buffer blocks.
package layer_buf_pkg;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_ROWS   = 30;
    localparam int DEF_COLS   = 30;
    localparam int DEF_ADDR_W = 16;

    // Raster stream state machine.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2
    } strm_state_e;

    // True when (row, col) addresses the last word of a ROWS x COLS map.
    function automatic logic is_last_pixel(input logic [31:0] row, input logic [31:0] col,
                                           input int rows, input int cols);
        return (row == 32'(rows - 1)) && (col == 32'(cols - 1));
    endfunction

endpackage

// File: rtl/fmap_bank.sv
// One ROWS x COLS feature-map bank: cleared by reset, one write port and
// two combinational read ports (random access and raster stream).
module fmap_bank
    import layer_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(ROWS)-1:0]   wr_row,
    input  logic [$clog2(COLS)-1:0]   wr_col,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [$clog2(ROWS)-1:0]   ra_row,
    input  logic [$clog2(COLS)-1:0]   ra_col,
    output logic [DATA_W-1:0]         ra_data,
    input  logic [$clog2(ROWS)-1:0]   sa_row,
    input  logic [$clog2(COLS)-1:0]   sa_col,
    output logic [DATA_W-1:0]         sa_data
);

    logic [DATA_W-1:0] mem_q [ROWS][COLS];

    // Storage: whole array cleared on reset, single-word write otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else if (wr_en) begin
            mem_q[wr_row][wr_col] <= wr_data;
        end
    end

    // Combinational read ports; the caller guarantees in-range addresses.
    always_comb begin
        ra_data = mem_q[ra_row][ra_col];
        sa_data = mem_q[sa_row][sa_col];
    end

endmodule

// File: rtl/layer_result_pingpong_buf.sv
// Double-buffered conv-layer result store: compute writes one bank while the
// next layer reads the other, by random reads or a raster valid/ready stream.
module layer_result_pingpong_buf
    import layer_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_row,
    input  logic [ADDR_W-1:0] wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_row,
    input  logic [ADDR_W-1:0] rd_col,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              strm_start,
    output logic [DATA_W-1:0] strm_data,
    output logic              strm_valid,
    input  logic              strm_ready,
    output logic              strm_last,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              busy,
    output logic              addr_err
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] LAST_R = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_C = CW'(COLS - 1);

    strm_state_e       state_q, state_d;
    logic              bank_sel_q, bank_sel_d;
    logic              swap_pend_q, swap_pend_d;
    logic              swap_ack_q, swap_ack_d;
    logic              busy_q, busy_d;
    logic              addr_err_q, addr_err_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              strm_valid_q, strm_valid_d;
    logic              strm_last_q, strm_last_d;
    logic [DATA_W-1:0] strm_data_q, strm_data_d;
    logic [RW-1:0]     r_q, r_d;
    logic [CW-1:0]     c_q, c_d;

    logic              wr_in_s, rd_in_s, rd_acc_s;
    logic              we0_s, we1_s;
    logic              swap_do_s, strm_load_s, pix_last_s;
    logic [DATA_W-1:0] ra_data0_s, ra_data1_s, sa_data0_s, sa_data1_s;
    logic [DATA_W-1:0] rd_word_s, strm_word_s;

    // Address range checks at full port width, and bank write steering.
    // The write goes to the current write bank, so a write coincident with
    // a swap lands in the bank that is about to become the read bank.
    always_comb begin
        wr_in_s  = (wr_row < ADDR_W'(ROWS)) && (wr_col < ADDR_W'(COLS));
        rd_in_s  = (rd_row < ADDR_W'(ROWS)) && (rd_col < ADDR_W'(COLS));
        rd_acc_s = rd_en && !busy_q;
        we0_s    = wr_en && wr_in_s && !bank_sel_q;
        we1_s    = wr_en && wr_in_s && bank_sel_q;
    end

    fmap_bank #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (we0_s),
        .wr_row  (wr_row[RW-1:0]),
        .wr_col  (wr_col[CW-1:0]),
        .wr_data (wr_data),
        .ra_row  (rd_row[RW-1:0]),
        .ra_col  (rd_col[CW-1:0]),
        .ra_data (ra_data0_s),
        .sa_row  (r_q),
        .sa_col  (c_q),
        .sa_data (sa_data0_s)
    );

    fmap_bank #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS)) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (we1_s),
        .wr_row  (wr_row[RW-1:0]),
        .wr_col  (wr_col[CW-1:0]),
        .wr_data (wr_data),
        .ra_row  (rd_row[RW-1:0]),
        .ra_col  (rd_col[CW-1:0]),
        .ra_data (ra_data1_s),
        .sa_row  (r_q),
        .sa_col  (c_q),
        .sa_data (sa_data1_s)
    );

    // Read bank selection: bank_sel=0 means bank1 is the read bank.
    always_comb begin
        if (bank_sel_q) begin
            rd_word_s   = ra_data0_s;
            strm_word_s = sa_data0_s;
        end else begin
            rd_word_s   = ra_data1_s;
            strm_word_s = sa_data1_s;
        end
    end

    // Random-read path and sticky address error.
    always_comb begin
        rd_valid_d = rd_acc_s;
        if (rd_acc_s) begin
            rd_data_d = rd_in_s ? rd_word_s : '0;
        end else begin
            rd_data_d = rd_data_q;
        end
        addr_err_d = addr_err_q | (wr_en & ~wr_in_s) | (rd_acc_s & ~rd_in_s);
    end

    // Stream FSM next state, swap arbitration and stream output loading.
    always_comb begin
        state_d      = state_q;
        swap_pend_d  = swap_pend_q;
        strm_valid_d = strm_valid_q;
        strm_last_d  = strm_last_q;
        strm_data_d  = strm_data_q;
        r_d          = r_q;
        c_d          = c_q;
        swap_do_s    = 1'b0;
        strm_load_s  = 1'b0;
        pix_last_s   = is_last_pixel(32'(r_q), 32'(c_q), ROWS, COLS);

        case (state_q)
            ST_IDLE: begin
                // A pending swap wins over a stream start in the same cycle.
                if (swap_pend_q) begin
                    swap_do_s = 1'b1;
                end else if (strm_start) begin
                    strm_load_s = 1'b1;
                    if (swap_req) begin
                        swap_pend_d = 1'b1;
                    end else begin
                        swap_pend_d = swap_pend_q;
                    end
                end else if (swap_req) begin
                    swap_do_s = 1'b1;
                end else begin
                    swap_do_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (swap_req) begin
                    swap_pend_d = 1'b1;
                end else begin
                    swap_pend_d = swap_pend_q;
                end
                if (!strm_valid_q || strm_ready) begin
                    strm_load_s = 1'b1;
                end else begin
                    strm_load_s = 1'b0;
                end
            end
            ST_LAST: begin
                if (strm_valid_q && strm_ready) begin
                    strm_valid_d = 1'b0;
                    strm_last_d  = 1'b0;
                    state_d      = ST_IDLE;
                    // The swap executes on the edge that returns us to IDLE.
                    if (swap_pend_q || swap_req) begin
                        swap_do_s = 1'b1;
                    end else begin
                        swap_do_s = 1'b0;
                    end
                end else if (swap_req) begin
                    swap_pend_d = 1'b1;
                end else begin
                    swap_pend_d = swap_pend_q;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                strm_valid_d = 1'b0;
                strm_last_d  = 1'b0;
            end
        endcase

        if (swap_do_s) begin
            swap_pend_d = 1'b0;
        end else begin
            swap_pend_d = swap_pend_d;
        end

        if (strm_load_s) begin
            strm_data_d  = strm_word_s;
            strm_valid_d = 1'b1;
            strm_last_d  = pix_last_s;
            state_d      = pix_last_s ? ST_LAST : ST_RUN;
            if (c_q == LAST_C) begin
                c_d = '0;
                r_d = pix_last_s ? '0 : r_q + RW'(1);
            end else begin
                c_d = c_q + CW'(1);
                r_d = r_q;
            end
        end else begin
            c_d = c_q;
            r_d = r_q;
        end

        bank_sel_d = bank_sel_q ^ swap_do_s;
        swap_ack_d = swap_do_s;
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bank_sel_q   <= 1'b0;
            swap_pend_q  <= 1'b0;
            swap_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
            addr_err_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            strm_valid_q <= 1'b0;
            strm_last_q  <= 1'b0;
            strm_data_q  <= '0;
            r_q          <= '0;
            c_q          <= '0;
        end else begin
            state_q      <= state_d;
            bank_sel_q   <= bank_sel_d;
            swap_pend_q  <= swap_pend_d;
            swap_ack_q   <= swap_ack_d;
            busy_q       <= busy_d;
            addr_err_q   <= addr_err_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            strm_valid_q <= strm_valid_d;
            strm_last_q  <= strm_last_d;
            strm_data_q  <= strm_data_d;
            r_q          <= r_d;
            c_q          <= c_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign strm_data  = strm_data_q;
    assign strm_valid = strm_valid_q;
    assign strm_last  = strm_last_q;
    assign swap_ack   = swap_ack_q;
    assign busy       = busy_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_layer_result_pingpong_buf.sv
// Self-checking bench for layer_result_pingpong_buf: table of single-cycle
// access vectors, then raster streams checked against a queue of expected words.
module tb_layer_result_pingpong_buf;

    localparam int DW   = 128;
    localparam int ROWS = 30;
    localparam int COLS = 30;
    localparam int AW   = 16;
    localparam int NPIX = ROWS * COLS;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_row, wr_col;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_row, rd_col;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          strm_start;
    logic [DW-1:0] strm_data;
    logic          strm_valid, strm_ready, strm_last;
    logic          swap_req, swap_ack, busy, addr_err;

    layer_result_pingpong_buf #(.DATA_W(DW), .ROWS(ROWS), .COLS(COLS), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data), .rd_valid(rd_valid),
        .strm_start(strm_start), .strm_data(strm_data), .strm_valid(strm_valid),
        .strm_ready(strm_ready), .strm_last(strm_last),
        .swap_req(swap_req), .swap_ack(swap_ack), .busy(busy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit          rd;
        bit          sw;
        logic [15:0] row;
        logic [15:0] col;
        logic [DW-1:0] data;
        bit          e_valid;
        logic [DW-1:0] e_data;
        bit          e_err;
        bit          e_ack;
    } vec_t;

    vec_t          vecs [16];
    int            n_vec  = 0;
    int            n_miss = 0;
    logic [DW-1:0] model_mem [2][NPIX];
    bit            model_sel;
    logic [DW-1:0] sb_q [$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        rd_en = 1'b0; rd_row = '0; rd_col = '0;
        strm_start = 1'b0; strm_ready = 1'b0; swap_req = 1'b0;
    endtask

    task automatic model_clear();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NPIX; i++)
                model_mem[b][i] = '0;
        model_sel = 1'b0;
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < NPIX; i++) begin
            wr_en = 1'b1; wr_row = AW'(i / COLS); wr_col = AW'(i % COLS);
            wr_data = DW'(base + i);
            model_mem[model_sel][i] = DW'(base + i);
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("swap_ack", swap_ack, 1'b1);
        model_sel = ~model_sel;
    endtask

    task automatic do_read(input int row, input int col, input logic [DW-1:0] exp);
        rd_en = 1'b1; rd_row = AW'(row); rd_col = AW'(col);
        step();
        rd_en = 1'b0;
        chk("rd_valid", rd_valid, 1'b1);
        chk("rd_data", rd_data, exp);
    endtask

    // Stream the read bank; optionally request a swap (with a concurrent write)
    // at handshake swap_at, or assert reset at handshake rst_at.
    task automatic run_stream(input bit toggle, input int swap_at, input int rst_at);
        int            beat;
        bit            stalled, hs, did_rst;
        logic [DW-1:0] held_d, prev_rd, exp_w;
        logic          held_l;
        beat = 0; stalled = 1'b0; did_rst = 1'b0; held_d = '0; held_l = 1'b0;
        for (int i = 0; i < NPIX; i++) sb_q.push_back(model_mem[model_sel ^ 1'b1][i]);
        prev_rd = rd_data;
        strm_start = 1'b1;
        step();
        strm_start = 1'b0;
        chk("first_valid", strm_valid, 1'b1);
        chk("busy_run", busy, 1'b1);
        for (int cyc = 0; cyc < 8 * NPIX && sb_q.size() != 0; cyc++) begin
            strm_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            chk("no_early_ack", swap_ack, 1'b0);
            if (cyc > 0) begin
                chk("rd_ignored_valid", rd_valid, 1'b0);
                chk("rd_ignored_hold", rd_data, prev_rd);
            end
            if (stalled) begin
                chk("stall_valid", strm_valid, 1'b1);
                chk("stall_data", strm_data, held_d);
                chk("stall_last", strm_last, held_l);
            end
            stalled = strm_valid && !strm_ready;
            held_d  = strm_data;
            held_l  = strm_last;
            hs      = strm_valid && strm_ready;
            rd_en = 1'b1; rd_row = '0; rd_col = '0;
            if (hs && swap_at >= 0 && beat == swap_at) begin
                swap_req = 1'b1;
                wr_en = 1'b1; wr_row = '0; wr_col = '0; wr_data = DW'(128'hDEAD);
                model_mem[model_sel][0] = DW'(128'hDEAD);
            end
            if (hs && rst_at >= 0 && beat == rst_at) begin
                rst = 1'b1;
                did_rst = 1'b1;
            end
            if (hs) begin
                exp_w = sb_q.pop_front();
                chk("strm_data", strm_data, exp_w);
                chk("strm_last", strm_last, (beat == NPIX - 1));
                beat++;
            end
            step();
            swap_req = 1'b0; wr_en = 1'b0;
            if (did_rst) begin
                rst = 1'b0;
                sb_q.delete();
                break;
            end
        end
        rd_en = 1'b0;
        strm_ready = 1'b0;
        chk("stream_complete", DW'(sb_q.size()), '0);
        if (!did_rst) begin
            chk("busy_done", busy, 1'b0);
            chk("valid_done", strm_valid, 1'b0);
            chk("ack_at_idle", swap_ack, (swap_at >= 0));
            if (swap_at >= 0) model_sel = ~model_sel;
            step();
            chk("ack_pulse_end", swap_ack, 1'b0);
        end
    endtask

    initial begin
        // {wr, rd, sw, row, col, data, e_valid, e_data, e_err, e_ack}
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'd0,     16'd0,  128'h0,    1'b1, 128'h0,    1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'd0,     16'd0,  128'h0,    1'b0, 128'h0,    1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'd3,     16'd5,  128'hA5,   1'b0, 128'h0,    1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'd0,     16'd0,  128'h0,    1'b0, 128'h0,    1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'd0,     16'd0,  128'h0,    1'b0, 128'h0,    1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'd3,     16'd5,  128'h0,    1'b1, 128'hA5,   1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'd0,     16'd0,  128'h0,    1'b0, 128'hA5,   1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'd30,    16'd0,  128'hFF,   1'b0, 128'hA5,   1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'd30,    16'd0,  128'h0,    1'b1, 128'h0,    1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'd0,     16'd30, 128'h0,    1'b1, 128'h0,    1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 16'd29,    16'd29, 128'h1234, 1'b0, 128'h0,    1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h0040,  16'd1,  128'hBEEF, 1'b0, 128'h0,    1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 16'd0,     16'd0,  128'h0,    1'b0, 128'h0,    1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 16'd29,    16'd29, 128'h0,    1'b1, 128'h1234, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 16'd0,     16'd1,  128'h0,    1'b1, 128'h0,    1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 16'd3,     16'd5,  128'h0,    1'b1, 128'h0,    1'b1, 1'b0};

        clear_inputs();
        model_clear();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_rd_data", rd_data, '0);
        chk("reset_strm_valid", strm_valid, 1'b0);
        chk("reset_strm_last", strm_last, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_swap_ack", swap_ack, 1'b0);
        chk("reset_addr_err", addr_err, 1'b0);

        // Single-cycle access vectors.
        for (int i = 0; i < 16; i++) begin
            wr_en = vecs[i].wr; rd_en = vecs[i].rd; swap_req = vecs[i].sw;
            wr_row = vecs[i].row; wr_col = vecs[i].col; wr_data = vecs[i].data;
            rd_row = vecs[i].row; rd_col = vecs[i].col;
            step();
            clear_inputs();
            chk($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].e_data);
            chk($sformatf("vec%0d_addr_err", i), addr_err, vecs[i].e_err);
            chk($sformatf("vec%0d_swap_ack", i), swap_ack, vecs[i].e_ack);
            if (vecs[i].wr && vecs[i].row < 16'd30 && vecs[i].col < 16'd30)
                model_mem[model_sel][int'(vecs[i].row) * COLS + int'(vecs[i].col)] = vecs[i].data;
            if (vecs[i].sw) model_sel = ~model_sel;
        end

        // Full-speed stream, then stream with ready toggling every cycle.
        fill(0);
        do_swap();
        run_stream(1'b0, -1, -1);
        run_stream(1'b1, -1, -1);

        // Swap requested mid-stream is deferred to the return to IDLE;
        // the concurrent write lands in the old write bank.
        fill(5000);
        run_stream(1'b0, 100, -1);
        do_read(0, 0, 128'hDEAD);
        do_read(1, 2, DW'(5000 + 32));
        do_read(29, 29, DW'(5000 + NPIX - 1));
        chk("addr_err_sticky", addr_err, 1'b1);

        // Reset in the middle of a stream.
        run_stream(1'b0, -1, 50);
        model_clear();
        chk("rst_mid_strm_valid", strm_valid, 1'b0);
        chk("rst_mid_strm_last", strm_last, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_addr_err", addr_err, 1'b0);
        chk("rst_mid_rd_valid", rd_valid, 1'b0);
        do_read(0, 0, '0);
        do_read(29, 29, '0);
        wr_en = 1'b1; wr_row = 16'd2; wr_col = 16'd2; wr_data = 128'h77;
        step();
        wr_en = 1'b0;
        do_read(2, 2, '0);
        do_swap();
        do_read(2, 2, 128'h77);
        do_read(0, 0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
